learn_note_judge: RTL and testbench
===================================

Name: learn_note_judge

Overview:
- Upstream stage of the auto/learn music player. Produces the `is_match` level that lets the player advance one note in learn mode.
- Samples the raw note keys (do..si) and the octave switches, then debounces them.
- Compares the debounced press against the expected note the player currently shows (one-hot lights plus high/low flags).
- Keeps a score, a miss count and a grade for the seven-segment/LED display path.

Parameters:
- DEBOUNCE_CYC, 2_000_000: consecutive stable cycles before a debounced input changes (20 ms at 100 MHz).
- TIMEOUT_CYC, 300_000_000: cycles without a correct press before a timeout miss is counted.
- SCORE_W, 8: width of the `score` and `miss_cnt` counters.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low
- enable  in  1  learn mode active (player in learn mode and not ended)
- score_clr  in  1  synchronous pulse; clears `score` and `miss_cnt`
- exp_lights  in  7  expected note, one-hot; bit6 = do ... bit0 = si; all-zero = rest
- exp_high  in  1  expected note is high octave
- exp_low  in  1  expected note is low octave
- note_idx  in  32  player's current note index; any change means a new note
- keys  in  7  raw note keys, same bit order as `exp_lights`, asynchronous to clk
- oct_up  in  1  raw high-octave switch
- oct_down  in  1  raw low-octave switch
- is_match  out  1  registered; 1 = player may advance
- score  out  SCORE_W  correct notes, saturating
- miss_cnt  out  SCORE_W  wrong presses plus timeouts, saturating
- grade  out  2  3 = perfect ... 0 = poor
- judge_state  out  3  current FSM state encoding, for debug LEDs

Behaviour:

Reset (reset = 0):
- FSM goes to IDLE.
- All outputs 0.
- Debounced values 0; timeout counter 0; stored `note_idx` 0.

Input conditioning:
- 2-FF synchronizer on each of the 9 raw inputs.
- Per-input debounce counter. The debounced value takes the synchronized value only after DEBOUNCE_CYC consecutive cycles of disagreement; any agreement resets that counter.

Press decoding (combinational on debounced values):
- `press_valid` = exactly one key bit set, AND not (oct_up AND oct_down).
- `press_ok` = press_valid AND keys == exp_lights AND oct_up == exp_high AND oct_down == exp_low.
- `press_bad` = press_valid AND not press_ok.
- Multiple keys pressed, or both octave switches on: treated as no press.

FSM (encoding IDLE = 0, WAIT = 1, MATCH = 2, WRONG = 3, RELEASE = 4):
- Any state with enable = 0 → IDLE. Score and miss_cnt are retained.
- IDLE:
  - enable = 1 → RELEASE (a key held on entry must not count).
  - Latch `note_idx`.
- WAIT, checked in this order:
  - exp_lights == 0 (rest) → MATCH; no score change.
  - press_ok → MATCH; score +1.
  - press_bad → WRONG; miss_cnt +1.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC-1: miss_cnt +1, counter to 0, stay in WAIT.
  - Timeout counter clears on every exit from WAIT.
- MATCH:
  - is_match = 1.
  - On `note_idx` ≠ latched value → latch the new value, go to RELEASE, is_match = 0 from the next cycle.
- WRONG:
  - is_match = 0.
  - When debounced keys are all 0 → WAIT.
- RELEASE:
  - is_match = 0.
  - When debounced keys are all 0 → WAIT.
  - Consequence: a repeated identical note requires a fresh press.

Outputs and timing:
- `is_match` is registered and asserts the cycle after entering MATCH.
- Counter updates take effect on the transition edge.
- Counters saturate at 2^SCORE_W-1.
- score_clr together with an increment in the same cycle: clear wins, result 0.
- `grade` is registered with 1-cycle latency:
  - miss_cnt == 0 → 3
  - miss_cnt ≤ 2 → 2
  - miss_cnt ≤ 5 → 1
  - otherwise → 0
- A `note_idx` change seen in WAIT or WRONG only updates the latched value; no state change.

Reset mid-operation:
- Immediate return to IDLE; all outputs 0 asynchronously.

Test Plan (bench uses DEBOUNCE_CYC = 4, TIMEOUT_CYC = 50):
1. Reset, enable = 1, exp_lights = 7'b0010000 (mi), press keys = 7'b0010000 for 10 cycles → is_match = 1 about 7 cycles after the press (2 sync + 4 debounce + 1); score = 1; miss_cnt = 0; grade = 3.
2. Expected re (7'b0100000), press fa (7'b0001000) → WRONG state, miss_cnt = 1, is_match = 0. Release, then press re → MATCH, score = 1, grade = 2.
3. Expected mi with exp_high = 1; press mi with oct_up = 0 → miss_cnt +1. Press mi with oct_up = 1 → is_match = 1.
4. No press for 120 cycles in WAIT → miss_cnt = 2 (at cycles 50 and 100). Set exp_lights = 0 → is_match = 1 with no score change.
5. Hold a key through a match, then change note_idx to the same expected note → is_match drops to 0 and stays 0 until release and re-press. Separately, pressing two keys together → no score or miss change.
6. Drop enable in MATCH → IDLE, is_match = 0, score retained. Pulse score_clr on the same cycle as a correct press → score = 0. Assert reset mid-debounce → all outputs 0 immediately.

Source files
------------

// File: rtl/learn_note_judge.sv
// learn_note_judge
//   Upstream judge for the learn-mode music player. Synchronizes and
//   debounces the raw note keys and octave switches, compares a single
//   debounced press against the note the player is showing, and raises
//   is_match so the player may advance. Also keeps a saturating score,
//   a saturating miss count and a 2-bit grade for the display path.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low
//   enable       learn mode active
//   score_clr    synchronous clear of score and miss_cnt (wins over increments)
//   exp_lights   expected note, one-hot, bit6 = do ... bit0 = si, 0 = rest
//   exp_high     expected note is high octave
//   exp_low      expected note is low octave
//   note_idx     player's note index; any change means a new note
//   keys         raw note keys (asynchronous)
//   oct_up       raw high-octave switch (asynchronous)
//   oct_down     raw low-octave switch (asynchronous)
//   is_match     registered; 1 = player may advance
//   score        correct notes, saturating
//   miss_cnt     wrong presses plus timeouts, saturating
//   grade        3 = perfect ... 0 = poor, one cycle behind miss_cnt
//   judge_state  FSM state encoding for debug LEDs
//
// Handshake: there is no valid/ready pair here. is_match is a level: it is
// held high for as long as the judge sits in MATCH and drops the cycle
// after the player moves note_idx on (or enable drops).

module learn_note_judge #(
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int TIMEOUT_CYC  = 300_000_000,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               score_clr,
  input  logic [6:0]         exp_lights,
  input  logic               exp_high,
  input  logic               exp_low,
  input  logic [31:0]        note_idx,
  input  logic [6:0]         keys,
  input  logic               oct_up,
  input  logic               oct_down,
  output logic               is_match,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_cnt,
  output logic [1:0]         grade,
  output logic [2:0]         judge_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_MATCH   = 3'd2,
    S_WRONG   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: bits [8:2] keys, [1] oct_up, [0] oct_down
  // ---------------------------------------------------------------------
  logic [8:0]      raw;
  logic [8:0]      sync1_q, sync2_q;
  logic [8:0]      deb_q;
  logic [DB_W-1:0] db_cnt_q [9];

  assign raw = {keys, oct_up, oct_down};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 9; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 9; i++) begin
        // The counter only runs while the synchronized value disagrees with
        // the debounced one; the flip happens on the DEBOUNCE_CYC-th
        // consecutive disagreeing cycle.
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
            deb_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Press decoding on debounced values
  // ---------------------------------------------------------------------
  logic [6:0] deb_keys;
  logic       deb_up, deb_dn;
  logic       one_key, press_valid, press_ok, press_bad;

  assign deb_keys = deb_q[8:2];
  assign deb_up   = deb_q[1];
  assign deb_dn   = deb_q[0];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
  assign one_key     = (deb_keys != 7'd0) && ((deb_keys & (deb_keys - 7'd1)) == 7'd0);
  assign press_valid = one_key && !(deb_up && deb_dn);
  assign press_ok    = press_valid && (deb_keys == exp_lights) &&
                       (deb_up == exp_high) && (deb_dn == exp_low);
  assign press_bad   = press_valid && !press_ok;

  // ---------------------------------------------------------------------
  // Judge FSM
  // ---------------------------------------------------------------------
  state_t             state_q;
  logic               is_match_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [31:0]        note_q;
  logic [SCORE_W-1:0] score_q, miss_q;
  logic [1:0]         grade_q;

  logic score_inc, miss_inc, to_hit;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Counter events mirror the WAIT priority order: rest, good, bad, timeout.
  always_comb begin
    score_inc = 1'b0;
    miss_inc  = 1'b0;
    if (enable && (state_q == S_WAIT) && (exp_lights != 7'd0)) begin
      if (press_ok)       score_inc = 1'b1;
      else if (press_bad) miss_inc  = 1'b1;
      else if (to_hit)    miss_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      is_match_q <= 1'b0;
      to_cnt_q   <= '0;
      note_q     <= '0;
      score_q    <= '0;
      miss_q     <= '0;
      grade_q    <= 2'd0;
    end else begin
      // Tracking note_idx every cycle makes note_idx != note_q a one-cycle
      // change detector; only MATCH acts on it.
      note_q <= note_idx;

      if (!enable) begin
        state_q    <= S_IDLE;
        is_match_q <= 1'b0;
        to_cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Pass through RELEASE so a key held on entry does not count.
            state_q    <= S_RELEASE;
            is_match_q <= 1'b0;
            to_cnt_q   <= '0;
          end
          S_WAIT: begin
            if (exp_lights == 7'd0 || press_ok) begin
              state_q    <= S_MATCH;
              is_match_q <= 1'b1;
              to_cnt_q   <= '0;
            end else if (press_bad) begin
              state_q    <= S_WRONG;
              is_match_q <= 1'b0;
              to_cnt_q   <= '0;
            end else if (to_hit) begin
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
          S_MATCH: begin
            if (note_idx != note_q) begin
              state_q    <= S_RELEASE;
              is_match_q <= 1'b0;
            end
          end
          S_WRONG, S_RELEASE: begin
            is_match_q <= 1'b0;
            if (deb_keys == 7'd0) state_q <= S_WAIT;
          end
          default: begin
            state_q    <= S_IDLE;
            is_match_q <= 1'b0;
            to_cnt_q   <= '0;
          end
        endcase
      end

      if (score_clr)                         score_q <= '0;
      else if (score_inc && (score_q != '1)) score_q <= score_q + SCORE_W'(1);

      if (score_clr)                        miss_q <= '0;
      else if (miss_inc && (miss_q != '1))  miss_q <= miss_q + SCORE_W'(1);

      if (miss_q == SCORE_W'(0))      grade_q <= 2'd3;
      else if (miss_q <= SCORE_W'(2)) grade_q <= 2'd2;
      else if (miss_q <= SCORE_W'(5)) grade_q <= 2'd1;
      else                            grade_q <= 2'd0;
    end
  end

  assign is_match    = is_match_q;
  assign score       = score_q;
  assign miss_cnt    = miss_q;
  assign grade       = grade_q;
  assign judge_state = state_q;

endmodule

// File: tb/tb_learn_note_judge.sv
module tb_learn_note_judge;

  localparam int DEB  = 4;
  localparam int TOUT = 50;
  localparam int SW   = 8;
  localparam int SMAX = 255;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable, score_clr;
  logic [6:0]    exp_lights;
  logic          exp_high, exp_low;
  logic [31:0]   note_idx;
  logic [6:0]    keys;
  logic          oct_up, oct_down;
  logic          is_match;
  logic [SW-1:0] score, miss_cnt;
  logic [1:0]    grade;
  logic [2:0]    judge_state;

  always #5 clk = ~clk;

  learn_note_judge #(.DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TOUT), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .score_clr(score_clr),
    .exp_lights(exp_lights), .exp_high(exp_high), .exp_low(exp_low),
    .note_idx(note_idx), .keys(keys), .oct_up(oct_up), .oct_down(oct_down),
    .is_match(is_match), .score(score), .miss_cnt(miss_cnt), .grade(grade),
    .judge_state(judge_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int m_score  = 0;
  int m_miss   = 0;
  logic [SW-1:0] exp_q[$];

  localparam logic [6:0] DO = 7'b1000000, RE = 7'b0100000, MI = 7'b0010000,
                         FA = 7'b0001000, SO = 7'b0000100, LA = 7'b0000010,
                         SI = 7'b0000001;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int grade_of(input int m);
    if (m == 0) return 3;
    if (m <= 2) return 2;
    if (m <= 5) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  // Counter scoreboard: expected values queued, popped against the DUT.
  task automatic check_counters(input string nm);
    logic [SW-1:0] e;
    exp_q.push_back(SW'(m_score));
    exp_q.push_back(SW'(m_miss));
    e = exp_q.pop_front();
    check({nm, ".score"}, int'(score), int'(e));
    e = exp_q.pop_front();
    check({nm, ".miss"}, int'(miss_cnt), int'(e));
    check({nm, ".grade"}, int'(grade), grade_of(m_miss));
  endtask

  // One isolated attempt: re-enter learn mode, show a note, press, release.
  task automatic run_trial(input logic [6:0] k, input logic up, input logic dn,
                           input logic [6:0] ex, input logic eh, input logic el,
                           input int ds, input int dm, input logic em,
                           input string nm);
    enable = 1'b0;
    tick(2);
    exp_lights = ex; exp_high = eh; exp_low = el;
    enable = 1'b1;
    tick(3);
    keys = k; oct_up = up; oct_down = dn;
    tick(10);
    keys = 7'd0; oct_up = 1'b0; oct_down = 1'b0;
    tick(10);
    m_score = sat(m_score + ds);
    m_miss  = sat(m_miss + dm);
    check({nm, ".match"}, int'(is_match), int'(em));
    check_counters(nm);
  endtask

  // Reference rules for a single held press.
  task automatic model_press(input logic [6:0] k, input logic up, input logic dn,
                             input logic [6:0] ex, input logic eh, input logic el,
                             output int ds, output int dm, output logic em);
    bit valid, ok;
    valid = ($countones(k) == 1) && !(up && dn);
    ok    = valid && (k == ex) && (up == eh) && (dn == el);
    ds = ok ? 1 : 0;
    dm = (valid && !ok) ? 1 : 0;
    em = ok;
  endtask

  typedef struct {
    logic [6:0] k;
    logic       up, dn;
    logic [6:0] ex;
    logic       eh, el;
    int         ds, dm;
    logic       em;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] rk, rex;
    logic       rup, rdn, reh, rel, rem;
    int         rds, rdm, sel;

    tbl[0] = '{MI, 1'b0, 1'b0, MI, 1'b0, 1'b0, 1, 0, 1'b1};
    tbl[1] = '{FA, 1'b0, 1'b0, RE, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[2] = '{MI, 1'b0, 1'b0, MI, 1'b1, 1'b0, 0, 1, 1'b0};
    tbl[3] = '{MI, 1'b1, 1'b0, MI, 1'b1, 1'b0, 1, 0, 1'b1};
    tbl[4] = '{DO | RE, 1'b0, 1'b0, DO, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[5] = '{SO, 1'b1, 1'b1, SO, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[6] = '{SI, 1'b0, 1'b1, SI, 1'b0, 1'b1, 1, 0, 1'b1};
    tbl[7] = '{LA, 1'b1, 1'b0, LA, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[8] = '{7'd0, 1'b1, 1'b0, FA, 1'b1, 1'b0, 0, 0, 1'b0};

    reset = 1'b0; enable = 1'b0; score_clr = 1'b0;
    exp_lights = 7'd0; exp_high = 1'b0; exp_low = 1'b0;
    note_idx = 32'd0; keys = 7'd0; oct_up = 1'b0; oct_down = 1'b0;
    tick(3);
    check("reset.match", int'(is_match), 0);
    check("reset.score", int'(score), 0);
    check("reset.miss", int'(miss_cnt), 0);
    check("reset.grade", int'(grade), 0);
    check("reset.state", int'(judge_state), 0);
    reset = 1'b1;

    // Exact press-to-match latency: 2 sync + 4 debounce + 1 FSM edge.
    exp_lights = MI;
    enable = 1'b1;
    tick(3);
    check("lat.wait_state", int'(judge_state), 1);
    keys = MI;
    tick(6);
    check("lat.early", int'(is_match), 0);
    tick(1);
    check("lat.match", int'(is_match), 1);
    check("lat.state", int'(judge_state), 2);
    m_score = 1;
    tick(3);
    keys = 7'd0;
    tick(10);
    check_counters("lat");

    // Press-decoding table.
    for (int i = 0; i < 9; i++)
      run_trial(tbl[i].k, tbl[i].up, tbl[i].dn, tbl[i].ex, tbl[i].eh, tbl[i].el,
                tbl[i].ds, tbl[i].dm, tbl[i].em, $sformatf("tbl%0d", i));

    // Timeout: misses on the 50th and 100th cycle spent in WAIT.
    enable = 1'b0;
    tick(2);
    exp_lights = MI; exp_high = 1'b0; exp_low = 1'b0;
    enable = 1'b1;
    tick(51);
    check("tout.before1", int'(miss_cnt), m_miss);
    tick(1);
    m_miss = sat(m_miss + 1);
    check("tout.first", int'(miss_cnt), m_miss);
    tick(49);
    check("tout.before2", int'(miss_cnt), m_miss);
    tick(1);
    m_miss = sat(m_miss + 1);
    check("tout.second", int'(miss_cnt), m_miss);
    tick(20);
    check("tout.still_wait", int'(judge_state), 1);
    exp_lights = 7'd0;
    tick(1);
    check("rest.match", int'(is_match), 1);
    tick(2);
    check_counters("rest");

    // Held key through a note change with the same expected note.
    enable = 1'b0;
    tick(2);
    exp_lights = MI;
    enable = 1'b1;
    tick(3);
    keys = MI;
    tick(10);
    m_score = sat(m_score + 1);
    check("hold.match", int'(is_match), 1);
    note_idx = note_idx + 32'd1;
    tick(1);
    check("hold.drop", int'(is_match), 0);
    tick(20);
    check("hold.stays_low", int'(is_match), 0);
    check("hold.release_state", int'(judge_state), 4);
    check_counters("hold");
    keys = 7'd0;
    tick(10);
    check("hold.wait_state", int'(judge_state), 1);
    keys = MI;
    tick(10);
    m_score = sat(m_score + 1);
    check("hold.repress", int'(is_match), 1);
    check_counters("hold2");

    // Enable drop in MATCH.
    enable = 1'b0;
    tick(1);
    check("dis.match", int'(is_match), 0);
    check("dis.state", int'(judge_state), 0);
    check("dis.score", int'(score), m_score);
    keys = 7'd0;
    tick(10);

    // score_clr alone, then together with a correct press.
    score_clr = 1'b1;
    tick(1);
    score_clr = 1'b0;
    m_score = 0; m_miss = 0;
    tick(1);
    check_counters("clr");
    enable = 1'b1;
    tick(3);
    keys = MI;
    tick(6);
    score_clr = 1'b1;
    tick(1);
    score_clr = 1'b0;
    check("clrinc.match", int'(is_match), 1);
    check("clrinc.score", int'(score), 0);
    keys = 7'd0;
    tick(10);

    // Randomized attempts against the reference rules.
    for (int t = 0; t < 40; t++) begin
      rex = 7'd1 << $urandom_range(0, 6);
      sel = $urandom_range(0, 2);
      reh = (sel == 1); rel = (sel == 2);
      if ($urandom_range(0, 1) == 1) begin
        rk = rex; rup = reh; rdn = rel;
      end else begin
        rk = 7'($urandom_range(0, 127));
        rup = 1'($urandom_range(0, 1));
        rdn = 1'($urandom_range(0, 1));
      end
      model_press(rk, rup, rdn, rex, reh, rel, rds, rdm, rem);
      run_trial(rk, rup, rdn, rex, reh, rel, rds, rdm, rem, $sformatf("rnd%0d", t));
    end

    // Miss counter saturation.
    for (int t = 0; t < 260; t++)
      run_trial(FA, 1'b0, 1'b0, RE, 1'b0, 1'b0, 0, 1, 1'b0, "sat");
    check("sat.miss_max", int'(miss_cnt), SMAX);

    // Asynchronous reset in the middle of a debounce.
    enable = 1'b1;
    exp_lights = MI;
    tick(3);
    keys = MI;
    tick(3);
    #2 reset = 1'b0;
    #1;
    check("areset.match", int'(is_match), 0);
    check("areset.score", int'(score), 0);
    check("areset.miss", int'(miss_cnt), 0);
    check("areset.grade", int'(grade), 0);
    check("areset.state", int'(judge_state), 0);
    keys = 7'd0;
    tick(2);
    reset = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
